// File: rtl/data_mem_controller.sv
// data_mem_controller: per-thread LSU ports arbitrated onto NUM_CHANNELS data-memory channels.
// Define DATA_MEM_RR_ARB_EN for round-robin consumer arbitration (default: fixed priority).
module data_mem_controller #(
    parameter int NUM_CONSUMERS = 8,
    parameter int NUM_CHANNELS  = 2,
    parameter int ADDR_WIDTH    = 8,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_CONSUMERS-1:0]              consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_WIDTH-1:0]   consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]              consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_WIDTH-1:0]   consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]              consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_WIDTH-1:0]   consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_WIDTH-1:0]   consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]              consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]               mem_read_valid,
    output logic [NUM_CHANNELS*ADDR_WIDTH-1:0]    mem_read_address,
    input  logic [NUM_CHANNELS-1:0]               mem_read_ready,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]    mem_read_data,
    output logic [NUM_CHANNELS-1:0]               mem_write_valid,
    output logic [NUM_CHANNELS*ADDR_WIDTH-1:0]    mem_write_address,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0]    mem_write_data,
    input  logic [NUM_CHANNELS-1:0]               mem_write_ready
);
    localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
    localparam int AW = ADDR_WIDTH;
    localparam int DW = DATA_WIDTH;

    typedef enum logic [2:0] {
        CH_IDLE,
        CH_READ_WAIT,
        CH_WRITE_WAIT,
        CH_READ_RELAY,
        CH_WRITE_RELAY
    } ch_state_e;

    ch_state_e                  state_q [NUM_CHANNELS];
    ch_state_e                  state_d [NUM_CHANNELS];
    logic [CW-1:0]              cur_q   [NUM_CHANNELS];
    logic [CW-1:0]              cur_d   [NUM_CHANNELS];
    logic [NUM_CONSUMERS-1:0]   busy_q, busy_d;
    logic [NUM_CHANNELS-1:0]    mrv_q, mrv_d, mwv_q, mwv_d;
    logic [NUM_CHANNELS*AW-1:0] mra_q, mra_d, mwa_q, mwa_d;
    logic [NUM_CHANNELS*DW-1:0] mwd_q, mwd_d;
    logic [NUM_CONSUMERS-1:0]   crr_q, crr_d, cwr_q, cwr_d;
    logic [NUM_CONSUMERS*DW-1:0] crd_q, crd_d;
`ifdef DATA_MEM_RR_ARB_EN
    logic [CW-1:0]              rr_ptr_q, rr_ptr_d;
`endif

    always_comb begin
        logic [NUM_CONSUMERS-1:0] claimed;
        logic [NUM_CONSUMERS-1:0] released;
        logic                     found;
        logic [CW-1:0]            j;
        int                       idx;
        int                       start;
        state_d  = state_q;
        cur_d    = cur_q;
        mrv_d    = mrv_q;
        mwv_d    = mwv_q;
        mra_d    = mra_q;
        mwa_d    = mwa_q;
        mwd_d    = mwd_q;
        crr_d    = crr_q;
        cwr_d    = cwr_q;
        crd_d    = crd_q;
        claimed  = '0;
        released = '0;
        found    = 1'b0;
        j        = '0;
        idx      = 0;
        start    = 0;
`ifdef DATA_MEM_RR_ARB_EN
        rr_ptr_d = rr_ptr_q;
        start    = int'(rr_ptr_q);
`endif
        // Claims from lower channels hide those consumers from higher channels.
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            j     = cur_q[c];
            found = 1'b0;
            unique case (state_q[c])
                CH_IDLE: begin
                    for (int k = 0; k < NUM_CONSUMERS; k++) begin
                        idx = start + k;
                        if (idx >= NUM_CONSUMERS) idx = idx - NUM_CONSUMERS;
                        if (!found && !busy_q[idx] && !claimed[idx] &&
                            (consumer_read_valid[idx] || consumer_write_valid[idx])) begin
                            found        = 1'b1;
                            claimed[idx] = 1'b1;
                            cur_d[c]     = CW'(idx);
                            if (consumer_read_valid[idx]) begin
                                mrv_d[c]           = 1'b1;
                                mra_d[c*AW +: AW]  = consumer_read_address[idx*AW +: AW];
                                state_d[c]         = CH_READ_WAIT;
                            end else begin
                                mwv_d[c]           = 1'b1;
                                mwa_d[c*AW +: AW]  = consumer_write_address[idx*AW +: AW];
                                mwd_d[c*DW +: DW]  = consumer_write_data[idx*DW +: DW];
                                state_d[c]         = CH_WRITE_WAIT;
                            end
`ifdef DATA_MEM_RR_ARB_EN
                            start    = (idx + 1 >= NUM_CONSUMERS) ? 0 : idx + 1;
                            rr_ptr_d = CW'(start);
`endif
                        end
                    end
                end
                CH_READ_WAIT: begin
                    if (mem_read_ready[c]) begin
                        mrv_d[c]          = 1'b0;
                        crr_d[j]          = 1'b1;
                        crd_d[j*DW +: DW] = mem_read_data[c*DW +: DW];
                        state_d[c]        = CH_READ_RELAY;
                    end
                end
                CH_WRITE_WAIT: begin
                    if (mem_write_ready[c]) begin
                        mwv_d[c]   = 1'b0;
                        cwr_d[j]   = 1'b1;
                        state_d[c] = CH_WRITE_RELAY;
                    end
                end
                CH_READ_RELAY: begin
                    if (!consumer_read_valid[j]) begin
                        crr_d[j]    = 1'b0;
                        released[j] = 1'b1;
                        state_d[c]  = CH_IDLE;
                    end
                end
                CH_WRITE_RELAY: begin
                    if (!consumer_write_valid[j]) begin
                        cwr_d[j]    = 1'b0;
                        released[j] = 1'b1;
                        state_d[c]  = CH_IDLE;
                    end
                end
                default: state_d[c] = CH_IDLE;
            endcase
        end
        // Releases take effect next cycle, so a freed consumer is never re-claimed same-edge.
        busy_d = (busy_q | claimed) & ~released;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                state_q[c] <= CH_IDLE;
                cur_q[c]   <= '0;
            end
            busy_q <= '0;
            mrv_q  <= '0;
            mwv_q  <= '0;
            mra_q  <= '0;
            mwa_q  <= '0;
            mwd_q  <= '0;
            crr_q  <= '0;
            cwr_q  <= '0;
            crd_q  <= '0;
`ifdef DATA_MEM_RR_ARB_EN
            rr_ptr_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            busy_q  <= busy_d;
            mrv_q   <= mrv_d;
            mwv_q   <= mwv_d;
            mra_q   <= mra_d;
            mwa_q   <= mwa_d;
            mwd_q   <= mwd_d;
            crr_q   <= crr_d;
            cwr_q   <= cwr_d;
            crd_q   <= crd_d;
`ifdef DATA_MEM_RR_ARB_EN
            rr_ptr_q <= rr_ptr_d;
`endif
        end
    end

    assign mem_read_valid       = mrv_q;
    assign mem_read_address     = mra_q;
    assign mem_write_valid      = mwv_q;
    assign mem_write_address    = mwa_q;
    assign mem_write_data       = mwd_q;
    assign consumer_read_ready  = crr_q;
    assign consumer_write_ready = cwr_q;
    assign consumer_read_data   = crd_q;

endmodule

// File: tb/tb_data_mem_controller.sv
// tb_data_mem_controller: directed and randomized checks of data_mem_controller
// against a memory array, an expected-contents array and LSU protocol watchers.
module tb_data_mem_controller;
    localparam int NC  = 8;
    localparam int NCH = 2;
    localparam int AW  = 8;
    localparam int DW  = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [NC-1:0]     rv, wv;
    logic [NC*AW-1:0]  ra, wa;
    logic [NC*DW-1:0]  wd;
    logic [NC-1:0]     crr, cwr;
    logic [NC*DW-1:0]  crd;
    logic [NCH-1:0]    mrv, mwv, mrr, mwr;
    logic [NCH*AW-1:0] mra, mwa;
    logic [NCH*DW-1:0] mrd, mwd;

    int                total = 0;
    int                bad = 0;
    int                mem_lat = 1;
    bit                mon_en = 1'b0;
    logic [NC-1:0]     rd_pend, wr_pend;
    logic [DW-1:0]     phys_mem [256];
    logic [DW-1:0]     ref_mem  [256];

    always #5 clk = ~clk;

    data_mem_controller dut (
        .clk                    (clk),
        .reset                  (reset),
        .consumer_read_valid    (rv),
        .consumer_read_address  (ra),
        .consumer_read_ready    (crr),
        .consumer_read_data     (crd),
        .consumer_write_valid   (wv),
        .consumer_write_address (wa),
        .consumer_write_data    (wd),
        .consumer_write_ready   (cwr),
        .mem_read_valid         (mrv),
        .mem_read_address       (mra),
        .mem_read_ready         (mrr),
        .mem_read_data          (mrd),
        .mem_write_valid        (mwv),
        .mem_write_address      (mwa),
        .mem_write_data         (mwd),
        .mem_write_ready        (mwr)
    );

    function automatic int pick_lat();
        return (mem_lat < 0) ? int'($urandom_range(0, 3)) : mem_lat;
    endfunction

    // Memory side: answers each valid after a latency with a one-cycle ready.
    task automatic responder();
        int rc [NCH];
        int wc [NCH];
        for (int c = 0; c < NCH; c++) begin
            rc[c] = -1;
            wc[c] = -1;
        end
        forever begin
            @(negedge clk);
            for (int c = 0; c < NCH; c++) begin
                if (reset) begin
                    mrr[c] = 1'b0;
                    mwr[c] = 1'b0;
                    rc[c]  = -1;
                    wc[c]  = -1;
                end else begin
                    if (mrr[c]) begin
                        mrr[c] = 1'b0;
                        rc[c]  = -1;
                    end else if (mrv[c]) begin
                        if (rc[c] < 0) rc[c] = pick_lat();
                        if (rc[c] == 0) begin
                            mrd[c*DW +: DW] = phys_mem[mra[c*AW +: AW]];
                            mrr[c] = 1'b1;
                        end else rc[c]--;
                    end else rc[c] = -1;
                    if (mwr[c]) begin
                        mwr[c] = 1'b0;
                        wc[c]  = -1;
                    end else if (mwv[c]) begin
                        if (wc[c] < 0) wc[c] = pick_lat();
                        if (wc[c] == 0) begin
                            phys_mem[mwa[c*AW +: AW]] = mwd[c*DW +: DW];
                            mwr[c] = 1'b1;
                        end else wc[c]--;
                    end else wc[c] = -1;
                end
            end
        end
    endtask

    // A ready to a consumer that is not waiting means a duplicate or misrouted service.
    task automatic monitor();
        logic [2:0] tag [NCH];
        bit         act [NCH];
        forever begin
            @(negedge clk);
            if (!reset) begin
                for (int j = 0; j < NC; j++) begin
                    if (crr[j]) begin
                        total++;
                        if (!rd_pend[j]) begin
                            bad++;
                            $display("FAIL spurious_rd_ready c%0d: got=1 want=0", j);
                        end
                    end
                    if (cwr[j]) begin
                        total++;
                        if (!wr_pend[j]) begin
                            bad++;
                            $display("FAIL spurious_wr_ready c%0d: got=1 want=0", j);
                        end
                    end
                end
                if (mon_en) begin
                    for (int c = 0; c < NCH; c++) begin
                        act[c] = mrv[c] | mwv[c];
                        tag[c] = mrv[c] ? mra[c*AW+5 +: 3] : mwa[c*AW+5 +: 3];
                    end
                    if (act[0] && act[1]) begin
                        total++;
                        if (tag[0] === tag[1]) begin
                            bad++;
                            $display("FAIL dup_service: both channels serve c%0d", tag[0]);
                        end
                    end
                end
            end
        end
    endtask

    task automatic lsu_read(input int j, input logic [AW-1:0] a, output logic [DW-1:0] d);
        bit ok;
        int n;
        ok = 1'b0;
        n  = 0;
        rd_pend[j]       = 1'b1;
        ra[j*AW +: AW]   = a;
        rv[j]            = 1'b1;
        while (n < 400 && !ok) begin
            @(negedge clk);
            n++;
            if (crr[j]) ok = 1'b1;
        end
        d     = crd[j*DW +: DW];
        rv[j] = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL rd_timeout c%0d: ready=0 want=1", j);
        end
        @(negedge clk);
        total++;
        if (crr[j] !== 1'b0) begin
            bad++;
            $display("FAIL rd_ready_clear c%0d: got=%b want=0", j, crr[j]);
        end
        rd_pend[j] = 1'b0;
    endtask

    task automatic lsu_write(input int j, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit ok;
        int n;
        ok = 1'b0;
        n  = 0;
        wr_pend[j]       = 1'b1;
        wa[j*AW +: AW]   = a;
        wd[j*DW +: DW]   = d;
        wv[j]            = 1'b1;
        while (n < 400 && !ok) begin
            @(negedge clk);
            n++;
            if (cwr[j]) ok = 1'b1;
        end
        wv[j] = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL wr_timeout c%0d: ready=0 want=1", j);
        end
        @(negedge clk);
        total++;
        if (cwr[j] !== 1'b0) begin
            bad++;
            $display("FAIL wr_ready_clear c%0d: got=%b want=0", j, cwr[j]);
        end
        wr_pend[j] = 1'b0;
        ref_mem[a] = d;
        total++;
        if (phys_mem[a] !== d) begin
            bad++;
            $display("FAIL wr_data c%0d a=%h: got=%h want=%h", j, a, phys_mem[a], d);
        end
    endtask

    task automatic check_rd(input string nm, input logic [DW-1:0] got, input logic [AW-1:0] a);
        total++;
        if (got !== ref_mem[a]) begin
            bad++;
            $display("FAIL %s a=%h: got=%h want=%h", nm, a, got, ref_mem[a]);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total += 8;
        if (mrv !== '0) begin bad++; $display("FAIL rst_mrv: got=%h want=0", mrv); end
        if (mwv !== '0) begin bad++; $display("FAIL rst_mwv: got=%h want=0", mwv); end
        if (mra !== '0) begin bad++; $display("FAIL rst_mra: got=%h want=0", mra); end
        if (mwa !== '0) begin bad++; $display("FAIL rst_mwa: got=%h want=0", mwa); end
        if (mwd !== '0) begin bad++; $display("FAIL rst_mwd: got=%h want=0", mwd); end
        if (crr !== '0) begin bad++; $display("FAIL rst_crr: got=%h want=0", crr); end
        if (cwr !== '0) begin bad++; $display("FAIL rst_cwr: got=%h want=0", cwr); end
        if (crd !== '0) begin bad++; $display("FAIL rst_crd: got=%h want=0", crd); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        logic [DW-1:0] d;
        mem_lat = 2;
        fork
            lsu_read(3, 8'h10, d);
            begin
                @(negedge clk);
                total++;
                if (mrv[0] !== 1'b1 || mra[7:0] !== 8'h10) begin
                    bad++;
                    $display("FAIL rd_issue: v=%b a=%h want v=1 a=10", mrv[0], mra[7:0]);
                end
            end
        join
        check_rd("rd_single", d, 8'h10);
        total++;
        if (d !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL rd_deadbeef: got=%h want=deadbeef", d);
        end
        total++;
        if (mrv !== '0) begin bad++; $display("FAIL rd_idle: mrv=%b want=0", mrv); end
    endtask

    task automatic test_single_write();
        mem_lat = 1;
        fork
            lsu_write(1, 8'h20, 32'h55);
            begin
                @(negedge clk);
                total++;
                if (mwv[0] !== 1'b1 || mwa[7:0] !== 8'h20 || mwd[31:0] !== 32'h55) begin
                    bad++;
                    $display("FAIL wr_issue: v=%b a=%h d=%h want 1/20/55",
                             mwv[0], mwa[7:0], mwd[31:0]);
                end
            end
        join
    endtask

    task automatic test_contention();
        logic [DW-1:0] d0, d1, d2;
        mem_lat = 3;
        fork
            lsu_read(0, 8'h30, d0);
            lsu_read(1, 8'h31, d1);
            lsu_read(2, 8'h32, d2);
            begin
                @(negedge clk);
                total++;
                if (mrv !== 2'b11 || mra !== 16'h3130) begin
                    bad++;
                    $display("FAIL contend_claim: v=%b a=%h want v=11 a=3130", mrv, mra);
                end
            end
        join
        check_rd("contend_c0", d0, 8'h30);
        check_rd("contend_c1", d1, 8'h31);
        check_rd("contend_c2", d2, 8'h32);
    endtask

    task automatic test_fixed_priority();
        logic [DW-1:0] d2, d6, d7;
        mem_lat = 2;
        fork
            lsu_read(7, 8'h47, d7);
            lsu_read(6, 8'h46, d6);
            lsu_read(2, 8'h42, d2);
            begin
                @(negedge clk);
                total++;
                if (mra !== 16'h4642) begin
                    bad++;
                    $display("FAIL prio_order: a=%h want 4642", mra);
                end
            end
        join
        check_rd("prio_c2", d2, 8'h42);
        check_rd("prio_c6", d6, 8'h46);
        check_rd("prio_c7", d7, 8'h47);
    endtask

    task automatic test_rw_priority();
        logic [DW-1:0] d;
        bit            rd_seen, wr_early, ok;
        int            n;
        mem_lat  = 1;
        rd_seen  = 1'b0;
        wr_early = 1'b0;
        rd_pend[5] = 1'b1;
        wr_pend[5] = 1'b1;
        ra[5*AW +: AW] = 8'hA0;
        wa[5*AW +: AW] = 8'hA4;
        wd[5*DW +: DW] = 32'h12345678;
        rv[5] = 1'b1;
        wv[5] = 1'b1;
        @(negedge clk);
        total++;
        if (mrv[0] !== 1'b1 || mwv !== '0) begin
            bad++;
            $display("FAIL rw_read_first: mrv=%b mwv=%b want 01/00", mrv, mwv);
        end
        n = 0;
        while (n < 400 && !rd_seen) begin
            if (cwr[5]) wr_early = 1'b1;
            if (crr[5]) rd_seen = 1'b1;
            else begin @(negedge clk); n++; end
        end
        d = crd[5*DW +: DW];
        rv[5] = 1'b0;
        check_rd("rw_rdata", d, 8'hA0);
        @(negedge clk);
        rd_pend[5] = 1'b0;
        ok = 1'b0;
        n  = 0;
        while (n < 400 && !ok) begin
            if (cwr[5]) ok = 1'b1;
            else begin @(negedge clk); n++; end
        end
        wv[5] = 1'b0;
        total++;
        if (!ok || wr_early) begin
            bad++;
            $display("FAIL rw_write_after: done=%b early=%b want 1/0", ok, wr_early);
        end
        @(negedge clk);
        wr_pend[5] = 1'b0;
        ref_mem[8'hA4] = 32'h12345678;
        total++;
        if (phys_mem[8'hA4] !== 32'h12345678) begin
            bad++;
            $display("FAIL rw_wdata: got=%h want=12345678", phys_mem[8'hA4]);
        end
    endtask

    task automatic test_reset_midop();
        logic [DW-1:0] d;
        mem_lat = 10;
        rd_pend[4] = 1'b1;
        ra[4*AW +: AW] = 8'h50;
        rv[4] = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (mrv[0] !== 1'b1) begin
            bad++;
            $display("FAIL midop_wait: mrv0=%b want 1", mrv[0]);
        end
        reset = 1'b1;
        rv[4] = 1'b0;
        @(negedge clk);
        total += 4;
        if (mrv !== '0 || mwv !== '0) begin
            bad++;
            $display("FAIL midop_mvalid: r=%b w=%b want 0", mrv, mwv);
        end
        if (crr !== '0 || cwr !== '0) begin
            bad++;
            $display("FAIL midop_ready: r=%h w=%h want 0", crr, cwr);
        end
        if (crd !== '0) begin bad++; $display("FAIL midop_rdata: got=%h want=0", crd); end
        if (mra !== '0) begin bad++; $display("FAIL midop_addr: got=%h want=0", mra); end
        reset = 1'b0;
        rd_pend[4] = 1'b0;
        mem_lat = 1;
        @(negedge clk);
        lsu_read(4, 8'h50, d);
        check_rd("midop_after", d, 8'h50);
    endtask

    task automatic lsu_thread(input int j);
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        for (int k = 0; k < 8; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            a = {3'(j), 5'($urandom_range(0, 31))};
            if ($urandom_range(0, 1) == 1) lsu_write(j, a, $urandom);
            else begin
                lsu_read(j, a, d);
                check_rd("rand_rd", d, a);
            end
        end
    endtask

    task automatic test_random();
        mem_lat = -1;
        mon_en  = 1'b1;
        fork
            lsu_thread(0);
            lsu_thread(1);
            lsu_thread(2);
            lsu_thread(3);
            lsu_thread(4);
            lsu_thread(5);
            lsu_thread(6);
            lsu_thread(7);
        join
        mon_en = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        rv      = '0;
        wv      = '0;
        ra      = '0;
        wa      = '0;
        wd      = '0;
        mrr     = '0;
        mwr     = '0;
        mrd     = '0;
        rd_pend = '0;
        wr_pend = '0;
        for (int i = 0; i < 256; i++) phys_mem[i] = $urandom;
        phys_mem[8'h10] = 32'hDEADBEEF;
        for (int i = 0; i < 256; i++) ref_mem[i] = phys_mem[i];
        fork
            responder();
            monitor();
        join_none
        test_reset();
        test_single_read();
        test_single_write();
        test_contention();
`ifndef DATA_MEM_RR_ARB_EN
        test_fixed_priority();
`endif
        test_rw_priority();
        test_reset_midop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
